uart_mmio: RTL and testbench

UART_MMIO -- requirements
Module: uart_mmio

---
 rtl/uart_mmio.sv | 345 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_mmio.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio.sv
// UART with a four-register memory-mapped interface (DATA, STATUS, DIVISOR, IRQ_EN),
// TX/RX FIFOs, 8N1 framing at a programmable divisor and a level interrupt.

module uart_mmio #(
    parameter int CLOCK_RATE = 24_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        sel,
    input  logic        wren,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RESET = 16'(CLOCK_RATE / BAUD_RATE);
    localparam logic [AW:0] PTR_ONE   = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic        wr_s, rd_s, status_wr_s;
    logic        unused_wdata_s;
    logic [31:0] rd_data_s, status_s;

    logic [15:0] div_r;
    logic [1:0]  irq_en_r;
    logic        tx_overrun_r, rx_overrun_r, frame_err_r;
    logic [31:0] rdata_r;
    logic        irq_r;

    logic [7:0]  tx_mem_r [FIFO_DEPTH];
    logic [AW:0] tx_wr_ptr_r, tx_rd_ptr_r;
    logic        tx_empty_s, tx_full_s, tx_push_req_s, tx_push_s, tx_drop_s, tx_pop_s;
    logic [7:0]  tx_head_s;

    logic [7:0]  rx_mem_r [FIFO_DEPTH];
    logic [AW:0] rx_wr_ptr_r, rx_rd_ptr_r;
    logic        rx_empty_s, rx_full_s, rx_push_req_s, rx_push_s, rx_drop_s, rx_pop_s;
    logic [7:0]  rx_head_s;

    state_t      tx_state_r, tx_state_n;
    logic [15:0] tx_cnt_r, tx_cnt_n, tx_div_r, tx_div_n;
    logic [2:0]  tx_bit_r, tx_bit_n;
    logic [7:0]  tx_shift_r, tx_shift_n;
    logic        tx_line_r, tx_line_n, tx_last_s, tx_busy_s;

    logic        rx_meta_r, rx_sync_r, rx_prev_r, rx_fall_s;
    state_t      rx_state_r, rx_state_n;
    logic [15:0] rx_cnt_r, rx_cnt_n, rx_div_r, rx_div_n;
    logic [2:0]  rx_bit_r, rx_bit_n;
    logic [7:0]  rx_shift_r, rx_shift_n;
    logic        rx_wait_r, rx_wait_n, rx_last_s, rx_half_s, rx_ferr_set_s;

    assign wr_s           = sel & wren;
    assign rd_s           = sel & ~wren;
    assign status_wr_s    = wr_s & (addr == 2'd1);
    assign unused_wdata_s = ^wdata[31:16];

    // A push into a full FIFO is still accepted when the same cycle pops.
    assign tx_empty_s    = (tx_wr_ptr_r == tx_rd_ptr_r);
    assign tx_full_s     = (tx_wr_ptr_r[AW] != tx_rd_ptr_r[AW]) &&
                           (tx_wr_ptr_r[AW-1:0] == tx_rd_ptr_r[AW-1:0]);
    assign tx_head_s     = tx_mem_r[tx_rd_ptr_r[AW-1:0]];
    assign tx_push_req_s = wr_s & (addr == 2'd0);
    assign tx_push_s     = tx_push_req_s & (~tx_full_s | tx_pop_s);
    assign tx_drop_s     = tx_push_req_s & tx_full_s & ~tx_pop_s;

    assign rx_empty_s    = (rx_wr_ptr_r == rx_rd_ptr_r);
    assign rx_full_s     = (rx_wr_ptr_r[AW] != rx_rd_ptr_r[AW]) &&
                           (rx_wr_ptr_r[AW-1:0] == rx_rd_ptr_r[AW-1:0]);
    assign rx_head_s     = rx_mem_r[rx_rd_ptr_r[AW-1:0]];
    assign rx_pop_s      = rd_s & (addr == 2'd0) & ~rx_empty_s;
    assign rx_push_s     = rx_push_req_s & (~rx_full_s | rx_pop_s);
    assign rx_drop_s     = rx_push_req_s & rx_full_s & ~rx_pop_s;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push_s) tx_mem_r[tx_wr_ptr_r[AW-1:0]] <= wdata[7:0];
        if (rx_push_s) rx_mem_r[rx_wr_ptr_r[AW-1:0]] <= rx_shift_r;
    end

    // FIFO pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_wr_ptr_r <= '0;
            tx_rd_ptr_r <= '0;
            rx_wr_ptr_r <= '0;
            rx_rd_ptr_r <= '0;
        end else begin
            if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
            if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
            if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
        end
    end

    assign tx_last_s = (tx_cnt_r == tx_div_r - 16'd1);
    assign tx_busy_s = (tx_state_r != ST_IDLE);

    // TX next state: the line value is registered alongside the state.
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_bit_n   = tx_bit_r;
        tx_shift_n = tx_shift_r;
        tx_div_n   = tx_div_r;
        tx_line_n  = tx_line_r;
        tx_pop_s   = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                if (!tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_n = tx_head_s;
                    tx_div_n   = div_r;
                    tx_cnt_n   = 16'd0;
                    tx_state_n = ST_START;
                    tx_line_n  = 1'b0;
                end else begin
                    tx_line_n  = 1'b1;
                end
            end
            ST_START: begin
                if (tx_last_s) begin
                    tx_cnt_n   = 16'd0;
                    tx_bit_n   = 3'd0;
                    tx_state_n = ST_DATA;
                    tx_line_n  = tx_shift_r[0];
                end else begin
                    tx_cnt_n   = tx_cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (tx_last_s) begin
                    tx_cnt_n = 16'd0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = ST_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n   = tx_bit_r + 3'd1;
                        tx_shift_n = {1'b0, tx_shift_r[7:1]};
                        tx_line_n  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                // Chain straight into the next start bit so queued frames leave no gap.
                if (tx_last_s && !tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_shift_n = tx_head_s;
                    tx_div_n   = div_r;
                    tx_cnt_n   = 16'd0;
                    tx_state_n = ST_START;
                    tx_line_n  = 1'b0;
                end else if (tx_last_s) begin
                    tx_state_n = ST_IDLE;
                    tx_line_n  = 1'b1;
                end else begin
                    tx_cnt_n   = tx_cnt_r + 16'd1;
                end
            end
            default: begin
                tx_state_n = ST_IDLE;
                tx_line_n  = 1'b1;
            end
        endcase
    end

    // TX state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'd0;
            tx_div_r   <= DIV_RESET;
            tx_line_r  <= 1'b1;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_shift_r <= tx_shift_n;
            tx_div_r   <= tx_div_n;
            tx_line_r  <= tx_line_n;
        end
    end

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= uart_rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;
    assign rx_last_s = (rx_cnt_r == rx_div_r - 16'd1);
    assign rx_half_s = (rx_cnt_r == (rx_div_r >> 1) - 16'd1);

    // RX next state; the half-bit count absorbs the synchroniser latency.
    always_comb begin
        rx_state_n    = rx_state_r;
        rx_cnt_n      = rx_cnt_r;
        rx_bit_n      = rx_bit_r;
        rx_shift_n    = rx_shift_r;
        rx_div_n      = rx_div_r;
        rx_wait_n     = rx_wait_r;
        rx_push_req_s = 1'b0;
        rx_ferr_set_s = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                if (rx_fall_s) begin
                    rx_state_n = ST_START;
                    rx_cnt_n   = 16'd0;
                    rx_div_n   = div_r;
                end else begin
                    rx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_half_s && rx_sync_r) begin
                    rx_state_n = ST_IDLE;
                end else if (rx_half_s) begin
                    rx_state_n = ST_DATA;
                    rx_cnt_n   = 16'd0;
                    rx_bit_n   = 3'd0;
                end else begin
                    rx_cnt_n   = rx_cnt_r + 16'd1;
                end
            end
            ST_DATA: begin
                if (rx_last_s) begin
                    rx_cnt_n   = 16'd0;
                    rx_shift_n = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_n = ST_STOP;
                    end else begin
                        rx_bit_n   = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_n = rx_cnt_r + 16'd1;
                end
            end
            ST_STOP: begin
                // After a framing error, stay here until the line is released.
                if (rx_wait_r) begin
                    if (rx_sync_r) begin
                        rx_wait_n  = 1'b0;
                        rx_state_n = ST_IDLE;
                    end else begin
                        rx_wait_n  = 1'b1;
                    end
                end else if (rx_last_s && rx_sync_r) begin
                    rx_push_req_s = 1'b1;
                    rx_state_n    = ST_IDLE;
                end else if (rx_last_s) begin
                    rx_ferr_set_s = 1'b1;
                    rx_wait_n     = 1'b1;
                end else begin
                    rx_cnt_n      = rx_cnt_r + 16'd1;
                end
            end
            default: begin
                rx_state_n = ST_IDLE;
                rx_wait_n  = 1'b0;
            end
        endcase
    end

    // RX state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= 16'd0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'd0;
            rx_div_r   <= DIV_RESET;
            rx_wait_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bit_r   <= rx_bit_n;
            rx_shift_r <= rx_shift_n;
            rx_div_r   <= rx_div_n;
            rx_wait_r  <= rx_wait_n;
        end
    end

    assign status_s = {24'd0, tx_overrun_r, tx_busy_s, frame_err_r, rx_overrun_r,
                       rx_full_s, rx_empty_s, tx_empty_s, tx_full_s};

    // Read mux.
    always_comb begin
        rd_data_s = 32'd0;
        case (addr)
            2'd0:    rd_data_s = {rx_empty_s, 23'd0, (rx_empty_s ? 8'd0 : rx_head_s)};
            2'd1:    rd_data_s = status_s;
            2'd2:    rd_data_s = {16'd0, div_r};
            2'd3:    rd_data_s = {30'd0, irq_en_r};
            default: rd_data_s = 32'd0;
        endcase
    end

    // Control registers, sticky flags (set beats clear), read data and interrupt.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_r        <= DIV_RESET;
            irq_en_r     <= 2'd0;
            tx_overrun_r <= 1'b0;
            rx_overrun_r <= 1'b0;
            frame_err_r  <= 1'b0;
            rdata_r      <= 32'd0;
            irq_r        <= 1'b0;
        end else begin
            if (wr_s && (addr == 2'd2) && (wdata[15:0] >= 16'd4)) div_r <= wdata[15:0];
            if (wr_s && (addr == 2'd3)) irq_en_r <= wdata[1:0];
            tx_overrun_r <= tx_drop_s     | (tx_overrun_r & ~(status_wr_s & wdata[7]));
            rx_overrun_r <= rx_drop_s     | (rx_overrun_r & ~(status_wr_s & wdata[4]));
            frame_err_r  <= rx_ferr_set_s | (frame_err_r  & ~(status_wr_s & wdata[5]));
            if (rd_s) rdata_r <= rd_data_s;
            irq_r <= (irq_en_r[0] & ~rx_empty_s) | (irq_en_r[1] & tx_empty_s);
        end
    end

    assign rdata   = rdata_r;
    assign irq     = irq_r;
    assign uart_tx = tx_line_r;

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: bus tasks, a serial-line monitor for uart_tx,
// a serial driver for uart_rx and queue-based reference models.

module tb_uart_mmio;
    localparam int DEPTH       = 4;
    localparam int DIV_DEFAULT = 24_000_000 / 115200;

    logic        clk = 1'b0;
    logic        rstn, sel, wren;
    logic [1:0]  addr;
    logic [31:0] wdata, rdata;
    logic        uart_rx, uart_tx, irq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         mon_div = DIV_DEFAULT;
    logic [8:0] mon_q[$];
    int         mon_start_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_mmio #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .wren(wren), .addr(addr), .wdata(wdata),
        .rdata(rdata), .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
    );

    // Decodes frames on uart_tx, sampling mid-bit with the divisor the bench expects.
    initial begin : tx_monitor
        int         d;
        logic [7:0] b;
        logic       sb;
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && uart_tx === 1'b0) begin
                d = mon_div;
                mon_start_q.push_back(cyc);
                repeat (d / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (d) @(negedge clk);
                sb = uart_tx;
                mon_q.push_back({sb, b});
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wren = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        sel = 1'b0; wren = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wren = 1'b0; addr = a;
        @(negedge clk);
        sel = 1'b0;
        d = rdata;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop, input int d);
        @(posedge clk); #1; uart_rx = 1'b0;
        repeat (d) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1; uart_rx = b[i];
            repeat (d) @(posedge clk);
        end
        #1; uart_rx = stop;
        repeat (d) @(posedge clk);
        #1; uart_rx = 1'b1;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (mon_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (mon_q.size() < n) begin
            bad++;
            $display("FAIL frame_timeout: got %0d frames, need %0d", mon_q.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h exp 0", rdata); end
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b exp 1", uart_tx); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b exp 0", irq); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL reset_status: got %h exp 00000006", rd); end
        bus_read(2'd3, rd);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_irq_en: got %h exp 0", rd); end
        bus_read(2'd2, rd);
        total++; if (rd !== 32'(DIV_DEFAULT)) begin bad++; $display("FAIL reset_divisor: got %0d exp %0d", rd, DIV_DEFAULT); end
        wait_cycles(3);
        total++; if (rdata !== 32'(DIV_DEFAULT)) begin bad++; $display("FAIL rdata_hold: got %h exp %h", rdata, DIV_DEFAULT); end
    endtask

    task automatic test_tx_exact();
        logic [9:0]  pat;
        logic [39:0] obs, expv;
        logic [31:0] rd;
        int          k;
        pat = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < 40; j++) expv[j] = pat[j / 4];
        bus_write(2'd2, 32'd4);
        mon_div = 4;
        bus_write(2'd0, 32'hA5);
        k = 0;
        do begin @(negedge clk); k++; end while (uart_tx !== 1'b0 && k < 3);
        total++; if (uart_tx !== 1'b0) begin bad++; $display("FAIL tx_start_latency: no start bit within %0d cycles", k); end
        for (int j = 0; j < 40; j++) begin
            obs[j] = uart_tx;
            if (j < 39) @(negedge clk);
        end
        total++; if (obs !== expv) begin bad++; $display("FAIL tx_a5_waveform: got %h exp %h", obs, expv); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL tx_busy_drop: status %h exp 00000006", rd); end
        wait_frames(1, 20);
        mon_q.delete(); mon_start_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  a, b, c;
        logic [31:0] rd;
        int          d0, d1;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        bus_write(2'd2, 32'd6);
        mon_div = 6;
        bus_write(2'd0, {24'd0, a});
        bus_write(2'd0, {24'd0, b});
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h44) begin bad++; $display("FAIL b2b_busy_status: got %h exp 00000044", rd); end
        bus_write(2'd2, 32'd4);
        mon_div = 4;
        bus_write(2'd0, {24'd0, c});
        wait_frames(3, 400);
        if (mon_q.size() >= 3) begin
            total++; if (mon_q[0] !== {1'b1, a}) begin bad++; $display("FAIL b2b_byte0: got %h exp %h", mon_q[0], {1'b1, a}); end
            total++; if (mon_q[1] !== {1'b1, b}) begin bad++; $display("FAIL b2b_byte1: got %h exp %h", mon_q[1], {1'b1, b}); end
            total++; if (mon_q[2] !== {1'b1, c}) begin bad++; $display("FAIL b2b_byte2: got %h exp %h", mon_q[2], {1'b1, c}); end
            d0 = mon_start_q[1] - mon_start_q[0];
            d1 = mon_start_q[2] - mon_start_q[1];
            total++; if (d0 != 60) begin bad++; $display("FAIL b2b_gap0: got %0d cycles exp 60", d0); end
            total++; if (d1 != 40) begin bad++; $display("FAIL b2b_gap1: got %0d cycles exp 40", d1); end
        end
        wait_cycles(30);
        mon_q.delete(); mon_start_q.delete();
    endtask

    task automatic test_tx_overrun();
        logic [7:0]  q[$];
        logic [7:0]  w;
        logic [31:0] rd, exp;
        int          fifo_cnt = 0;
        logic        ovr = 1'b0;
        bus_write(2'd2, 32'd6);
        mon_div = 6;
        w = 8'($urandom);
        bus_write(2'd0, {24'd0, w});
        q.push_back(w);
        for (int i = 0; i < 5; i++) begin
            w = 8'($urandom);
            bus_write(2'd0, {24'd0, w});
            if (fifo_cnt < DEPTH) begin q.push_back(w); fifo_cnt++; end
            else ovr = 1'b1;
        end
        exp = 32'h44 | ((fifo_cnt == DEPTH) ? 32'h1 : 32'h0) | (ovr ? 32'h80 : 32'h0);
        bus_read(2'd1, rd);
        total++; if (rd !== exp) begin bad++; $display("FAIL tx_overrun_set: status %h exp %h", rd, exp); end
        bus_write(2'd1, 32'h80);
        bus_read(2'd1, rd);
        total++; if (rd !== (exp & 32'h7F)) begin bad++; $display("FAIL tx_overrun_clear: status %h exp %h", rd, exp & 32'h7F); end
        wait_frames(q.size(), 500);
        wait_cycles(100);
        total++; if (mon_q.size() != q.size()) begin bad++; $display("FAIL tx_overrun_count: got %0d frames exp %0d", mon_q.size(), q.size()); end
        for (int i = 0; i < q.size() && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i] !== {1'b1, q[i]}) begin bad++; $display("FAIL tx_overrun_byte%0d: got %h exp %h", i, mon_q[i], {1'b1, q[i]}); end
        end
        mon_q.delete(); mon_start_q.delete();
    endtask

    task automatic test_random_tx();
        logic [7:0]  q[$];
        logic [7:0]  w;
        logic [31:0] rd;
        int          d, n;
        for (int r = 0; r < 3; r++) begin
            q.delete();
            d = $urandom_range(4, 9);
            n = $urandom_range(1, DEPTH + 1);
            bus_write(2'd2, 32'(d));
            mon_div = d;
            for (int i = 0; i < n; i++) begin
                w = 8'($urandom);
                bus_write(2'd0, {24'd0, w});
                q.push_back(w);
            end
            wait_frames(n, (n + 1) * 10 * d + 50);
            for (int i = 0; i < n && i < mon_q.size(); i++) begin
                total++;
                if (mon_q[i] !== {1'b1, q[i]}) begin bad++; $display("FAIL rand_tx r%0d b%0d: got %h exp %h", r, i, mon_q[i], {1'b1, q[i]}); end
            end
            wait_cycles(d);
            bus_read(2'd1, rd);
            total++; if (rd !== 32'h6) begin bad++; $display("FAIL rand_tx_status r%0d: got %h exp 00000006", r, rd); end
            mon_q.delete(); mon_start_q.delete();
        end
    endtask

    task automatic test_rx_basic();
        logic [31:0] rd;
        bus_write(2'd2, 32'd8);
        send_rx(8'h3C, 1'b1, 8);
        wait_cycles(10);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h2) begin bad++; $display("FAIL rx_status: got %h exp 00000002", rd); end
        bus_read(2'd0, rd);
        total++; if (rd !== 32'h3C) begin bad++; $display("FAIL rx_data: got %h exp 0000003c", rd); end
        bus_read(2'd0, rd);
        total++; if (rd !== 32'h80000000) begin bad++; $display("FAIL rx_empty_read: got %h exp 80000000", rd); end
    endtask

    task automatic test_rx_errors();
        logic [31:0] rd;
        logic [7:0]  b;
        b = 8'($urandom);
        send_rx(b, 1'b0, 8);
        wait_cycles(10);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h26) begin bad++; $display("FAIL frame_error_set: status %h exp 00000026", rd); end
        bus_write(2'd1, 32'h20);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL frame_error_clear: status %h exp 00000006", rd); end
        @(posedge clk); #1; uart_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1; uart_rx = 1'b1;
        wait_cycles(100);
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL glitch_status: status %h exp 00000006", rd); end
        b = 8'($urandom);
        send_rx(b, 1'b1, 8);
        wait_cycles(10);
        bus_read(2'd0, rd);
        total++; if (rd !== {24'd0, b}) begin bad++; $display("FAIL post_glitch_rx: got %h exp %h", rd, {24'd0, b}); end
    endtask

    task automatic test_irq_divisor();
        logic [31:0] rd;
        bus_write(2'd3, 32'd1);
        wait_cycles(2);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_idle: got %b exp 0", irq); end
        send_rx(8'($urandom), 1'b1, 8);
        wait_cycles(10);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx: got %b exp 1", irq); end
        bus_read(2'd0, rd);
        @(negedge clk);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_after_pop: got %b exp 0", irq); end
        bus_write(2'd3, 32'd2);
        wait_cycles(2);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_tx_empty: got %b exp 1", irq); end
        bus_write(2'd3, 32'd0);
        wait_cycles(2);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_disabled: got %b exp 0", irq); end
        bus_write(2'd2, 32'd2);
        bus_read(2'd2, rd);
        total++; if (rd !== 32'd8) begin bad++; $display("FAIL divisor_below_min: got %0d exp 8", rd); end
    endtask

    task automatic test_random_rx();
        logic [7:0]  q[$];
        logic [7:0]  b;
        logic [31:0] rd, exp;
        logic        ovr;
        int          d, n;
        for (int r = 0; r < 3; r++) begin
            d = $urandom_range(6, 12);
            n = $urandom_range(1, DEPTH + 2);
            ovr = 1'b0;
            bus_write(2'd2, 32'(d));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                send_rx(b, 1'b1, d);
                if (q.size() < DEPTH) q.push_back(b);
                else ovr = 1'b1;
            end
            wait_cycles(2 * d);
            exp = 32'h2 | ((q.size() == 0) ? 32'h4 : 32'h0) |
                  ((q.size() == DEPTH) ? 32'h8 : 32'h0) | (ovr ? 32'h10 : 32'h0);
            bus_read(2'd1, rd);
            total++; if (rd !== exp) begin bad++; $display("FAIL rand_rx_status r%0d: got %h exp %h", r, rd, exp); end
            while (q.size() > 0) begin
                exp = {24'd0, q.pop_front()};
                bus_read(2'd0, rd);
                total++; if (rd !== exp) begin bad++; $display("FAIL rand_rx_data r%0d: got %h exp %h", r, rd, exp); end
            end
            bus_read(2'd0, rd);
            total++; if (rd !== 32'h80000000) begin bad++; $display("FAIL rand_rx_drained r%0d: got %h exp 80000000", r, rd); end
            bus_write(2'd1, 32'h10);
            bus_read(2'd1, rd);
            total++; if (rd !== 32'h6) begin bad++; $display("FAIL rand_rx_clear r%0d: got %h exp 00000006", r, rd); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] rd;
        logic [39:0] obs;
        bus_write(2'd2, 32'd10);
        mon_div = 10;
        bus_write(2'd3, 32'd1);
        send_rx(8'($urandom), 1'b1, 10);
        wait_cycles(10);
        bus_read(2'd2, rd);
        bus_write(2'd0, 32'h00);
        bus_write(2'd0, 32'h55);
        wait_cycles(25);
        total++; if (uart_tx !== 1'b0 || irq !== 1'b1) begin bad++; $display("FAIL pre_reset: tx %b irq %b exp 0 1", uart_tx, irq); end
        #2; rstn = 1'b0;
        #1;
        total++; if (uart_tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx: got %b exp 1", uart_tx); end
        total++; if (irq !== 1'b0 || rdata !== 32'd0) begin bad++; $display("FAIL async_reset_out: irq %b rdata %h exp 0 0", irq, rdata); end
        wait_cycles(3);
        rstn = 1'b1;
        for (int j = 0; j < 40; j++) begin @(negedge clk); obs[j] = uart_tx; end
        total++; if (obs !== {40{1'b1}}) begin bad++; $display("FAIL frame_not_resumed: got %h exp all ones", obs); end
        bus_read(2'd1, rd);
        total++; if (rd !== 32'h6) begin bad++; $display("FAIL post_reset_status: got %h exp 00000006", rd); end
        bus_read(2'd2, rd);
        total++; if (rd !== 32'(DIV_DEFAULT)) begin bad++; $display("FAIL post_reset_divisor: got %0d exp %0d", rd, DIV_DEFAULT); end
        bus_read(2'd0, rd);
        total++; if (rd !== 32'h80000000) begin bad++; $display("FAIL post_reset_rx_empty: got %h exp 80000000", rd); end
    endtask

    initial begin
        rstn = 1'b0; sel = 1'b0; wren = 1'b0; addr = 2'd0; wdata = 32'd0; uart_rx = 1'b1;
        wait_cycles(3);
        rstn = 1'b1;
        test_reset();
        test_tx_exact();
        test_back_to_back();
        test_tx_overrun();
        test_random_tx();
        test_rx_basic();
        test_rx_errors();
        test_irq_divisor();
        test_random_rx();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
